// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and
// the baud divider helper used by the TX (and future RX) blocks.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int bps_cnt(input int clk_fre, input int bps);
        return clk_fre / bps;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: runs 0..BPS_CNT-1 while enabled, held at 0 otherwise,
// and flags the last cycle of each bit with a one-cycle tick.
module uart_baud_cnt #(
    parameter int BPS_CNT = 868
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic bit_tick
);

    localparam int CNT_W = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (!en || (cnt_q == CNT_MAX)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with valid/ready input and busy/done status.
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when parity is enabled)
// STOP   | stop bit(s) (1)
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 100_000_000,
    parameter int BPS       = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [DATA_BITS-1:0] uart_tx_data,
    input  logic                 uart_tx_valid,
    output logic                 uart_tx_ready,
    output logic                 uart_tx_busy,
    output logic                 uart_tx_done,
    output logic                 uart_txd
);

    localparam int BPS_CNT = bps_cnt(CLK_FRE, BPS);
    localparam int BIT_W   = 4;
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    if (BPS_CNT < 2) begin : g_bad_bps
        $error("uart_tx_cfg: CLK_FRE/BPS must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q;
    logic                 txd_d;
    logic                 done_d;
    logic                 bit_tick;
    logic                 accept;

    assign accept = uart_tx_valid && uart_tx_ready;

    uart_baud_cnt #(
        .BPS_CNT (BPS_CNT)
    ) u_baud_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (state_q != ST_IDLE),
        .bit_tick  (bit_tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            uart_txd     <= 1'b1;
            uart_tx_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            uart_txd     <= txd_d;
            uart_tx_done <= done_d;
            if (accept) begin
                par_q <= (PARITY == PAR_ODD) ? ~^uart_tx_data : ^uart_tx_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shreg_d   = uart_tx_data;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // txd is registered from the next state so each level starts on the
    // same edge the FSM enters the corresponding bit.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
            ST_PARITY: txd_d = par_q;
            default:   txd_d = 1'b1;
        endcase
    end

    assign uart_tx_ready = (state_q == ST_IDLE);
    assign uart_tx_busy  = ~uart_tx_ready;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations (8N1, 7E2, 8O1) at 10 clocks
// per bit; expected frames are queued at stimulus time and checked on the line.
module tb_uart_tx_cfg;

    localparam int BT = 10;

    typedef struct {
        logic [15:0] bits;
        int          nb;
        int          len;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic [8:0] data_bus;
    logic [2:0] valid_v;
    logic [2:0] ready_v, busy_v, done_v, txd_v;
    int         sel;
    logic       txd_s, done_s, ready_s, busy_s;

    frame_t exp_q[$];
    int     n_chk, n_pass, n_fail;
    int     frames_done;
    bit     mon_active;

    assign txd_s   = txd_v[sel];
    assign done_s  = done_v[sel];
    assign ready_s = ready_v[sel];
    assign busy_s  = busy_v[sel];

    uart_tx_cfg #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_tx_data(data_bus[7:0]), .uart_tx_valid(valid_v[0]),
        .uart_tx_ready(ready_v[0]), .uart_tx_busy(busy_v[0]), .uart_tx_done(done_v[0]), .uart_txd(txd_v[0]));

    uart_tx_cfg #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_tx_data(data_bus[6:0]), .uart_tx_valid(valid_v[1]),
        .uart_tx_ready(ready_v[1]), .uart_tx_busy(busy_v[1]), .uart_tx_done(done_v[1]), .uart_txd(txd_v[1]));

    uart_tx_cfg #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_tx_data(data_bus[7:0]), .uart_tx_valid(valid_v[2]),
        .uart_tx_ready(ready_v[2]), .uart_tx_busy(busy_v[2]), .uart_tx_done(done_v[2]), .uart_txd(txd_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic frame_t build_frame(input logic [8:0] d, input int nbits, input int par, input int stops);
        frame_t f;
        logic   p;
        int     k;
        f.bits = '1;
        f.bits[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            f.bits[1 + i] = d[i];
            p = p ^ d[i];
        end
        k = 1 + nbits;
        if (par != 0) begin
            f.bits[k] = (par == 1) ? ~p : p;
            k++;
        end
        for (int i = 0; i < stops; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.nb  = k;
        f.len = k * BT;
        return f;
    endfunction

    // Line monitor: n counts negedges since the start-bit negedge.
    initial begin
        frame_t f;
        int     n;
        bit     pw_chk;
        n = 0;
        pw_chk = 1'b0;
        mon_active = 1'b0;
        frames_done = 0;
        f = build_frame(9'h0, 8, 0, 1);
        forever begin
            @(negedge clk);
            if (pw_chk) begin
                check("done_width", {31'b0, done_s}, 32'd0);
                pw_chk = 1'b0;
            end
            if (!rst_n) begin
                mon_active = 1'b0;
                continue;
            end
            if (!mon_active) begin
                if (txd_s == 1'b0 && exp_q.size() > 0) begin
                    f = exp_q.pop_front();
                    mon_active = 1'b1;
                    n = 0;
                end else begin
                    continue;
                end
            end else begin
                n++;
            end
            if ((n % BT) == BT / 2 && (n / BT) < f.nb) begin
                check($sformatf("bit%0d", n / BT), {31'b0, txd_s}, {31'b0, f.bits[n / BT]});
            end
            if (done_s) begin
                check("frame_len", n, f.len);
                check("ready_at_done", {31'b0, ready_s}, 32'd1);
                frames_done++;
                pw_chk = 1'b1;
                mon_active = 1'b0;
                if (txd_s == 1'b0 && exp_q.size() > 0) begin
                    f = exp_q.pop_front();
                    mon_active = 1'b1;
                    n = 0;
                end
            end else if (n > f.len + 5) begin
                check("done_timeout", 32'd1, 32'd0);
                mon_active = 1'b0;
            end
        end
    end

    task automatic send(input int id, input logic [8:0] d);
        int t;
        sel = id;
        @(negedge clk);
        data_bus = d;
        valid_v  = 3'b001 << id;
        t = 0;
        while (ready_s !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", {31'b0, ready_s}, 32'd1);
        @(posedge clk);
        #1 valid_v = 3'b000;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || mon_active) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", {31'b0, mon_active}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0;
        int t;
        n_chk = 0; n_pass = 0; n_fail = 0;
        sel = 0;
        data_bus = '0;
        valid_v = 3'b000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd",   {29'b0, txd_v},   32'h7);
        check("rst_ready", {29'b0, ready_v}, 32'h7);
        check("rst_busy",  {29'b0, busy_v},  32'h0);
        check("rst_done",  {29'b0, done_v},  32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0xA5
        exp_q.push_back(build_frame(9'h0A5, 8, 0, 1));
        d0 = frames_done;
        send(0, 9'h0A5);
        wait_drain();
        check("t1_done_cnt", frames_done - d0, 32'd1);

        // 7E2 0x35
        exp_q.push_back(build_frame(9'h035, 7, 2, 2));
        d0 = frames_done;
        send(1, 9'h035);
        wait_drain();
        check("t2_done_cnt", frames_done - d0, 32'd1);

        // 8O1 0x00
        exp_q.push_back(build_frame(9'h000, 8, 1, 1));
        send(2, 9'h000);
        wait_drain();

        // back-to-back 0x11 then 0x22 with valid held
        exp_q.push_back(build_frame(9'h011, 8, 0, 1));
        exp_q.push_back(build_frame(9'h022, 8, 0, 1));
        d0 = frames_done;
        sel = 0;
        @(negedge clk);
        data_bus = 9'h011;
        valid_v = 3'b001;
        @(posedge clk);
        #1 data_bus = 9'h022;
        t = 0;
        while (ready_s !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("b2b_ready", {31'b0, ready_s}, 32'd1);
        @(posedge clk);
        #1 valid_v = 3'b000;
        wait_drain();
        check("t4_done_cnt", frames_done - d0, 32'd2);

        // valid while busy is ignored
        exp_q.push_back(build_frame(9'h05A, 8, 0, 1));
        send(0, 9'h05A);
        repeat (20) @(negedge clk);
        data_bus = 9'h0FF;
        valid_v = 3'b001;
        for (int i = 0; i < 3; i++) begin
            repeat (20) @(negedge clk);
            check("busy_ready", {31'b0, ready_s}, 32'd0);
            check("busy_busy",  {31'b0, busy_s},  32'd1);
        end
        valid_v = 3'b000;
        wait_drain();

        // reset mid-frame, then a clean 0x3C frame
        send(0, 9'h0C3);
        repeat (35) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_txd",   {31'b0, txd_s},   32'd1);
        check("abort_busy",  {31'b0, busy_s},  32'd0);
        check("abort_ready", {31'b0, ready_s}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(build_frame(9'h03C, 8, 0, 1));
        d0 = frames_done;
        send(0, 9'h03C);
        wait_drain();
        check("t6_done_cnt", frames_done - d0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
